// File: rtl/lsu_stage.sv
// Load/store stage: registers ALU results to writeback and runs req/gnt/rvalid data-memory
// transactions with byte-lane steering. Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module lsu_stage #(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [WORD_WIDTH-1:0] ex_data_i,
  input  logic [WORD_WIDTH-1:0] rdata2_store_i,
  input  logic [2:0]            funct3_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic                  reg_write_i,
  input  logic [4:0]            rd_i,
  output logic                  wb_valid_o,
  output logic                  wb_we_o,
  output logic [4:0]            wb_rd_o,
  output logic [WORD_WIDTH-1:0] wb_data_o,
  output logic                  misaligned_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic [WORD_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [WORD_WIDTH-1:0] data_wdata_o,
  input  logic [WORD_WIDTH-1:0] data_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t                  state;
  logic                    is_store_q;
  logic                    reg_write_q;
  logic [2:0]              funct3_q;
  logic [1:0]              off_q;
  logic [4:0]              rd_q;

  logic                    is_byte;
  logic                    is_half;
  logic                    is_mem;
  logic                    misaligned;
  logic [1:0]              off;
  logic [3:0]              be;
  logic [WORD_WIDTH-1:0]   wdata;

  logic                    ld_byte;
  logic                    ld_half;
  logic                    ld_signed;
  logic [WORD_WIDTH-1:0]   shifted;
  logic [WORD_WIDTH-1:0]   load_data;

  assign ready_o = (state == IDLE);

  // Request-side decode; offset bits that a size ignores are forced to zero.
  always_comb begin
    is_byte = (funct3_i == 3'b000) || (funct3_i == 3'b100);
    is_half = (funct3_i == 3'b001) || (funct3_i == 3'b101);
    is_mem  = mem_read_i | mem_write_i;
    off     = '0;
    be      = 4'b1111;
    wdata   = rdata2_store_i;
    if (is_byte) begin
      off   = ex_data_i[1:0];
      be    = 4'b0001 << off;
      wdata = {4{rdata2_store_i[7:0]}};
    end else if (is_half) begin
      off   = {ex_data_i[1], 1'b0};
      be    = 4'b0011 << off;
      wdata = {2{rdata2_store_i[15:0]}};
    end
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = is_mem & ((is_half & ex_data_i[0]) |
                           (~is_byte & ~is_half & (ex_data_i[1:0] != 2'b00)));
`else
    misaligned = 1'b0;
`endif
  end

  // Response-side formatting from the latched size and lane offset.
  always_comb begin
    ld_byte   = (funct3_q == 3'b000) || (funct3_q == 3'b100);
    ld_half   = (funct3_q == 3'b001) || (funct3_q == 3'b101);
    ld_signed = (funct3_q == 3'b000) || (funct3_q == 3'b001);
    shifted   = data_rdata_i >> {off_q, 3'b000};
    load_data = shifted;
    if (ld_byte) begin
      load_data = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
    end else if (ld_half) begin
      load_data = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      is_store_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      wb_valid_o   <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      misaligned_o <= 1'b0;
      data_req_o   <= 1'b0;
      data_addr_o  <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
    end else begin
      wb_valid_o   <= 1'b0;
      wb_we_o      <= 1'b0;
      misaligned_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (misaligned) begin
              wb_valid_o   <= 1'b1;
              misaligned_o <= 1'b1;
              wb_rd_o      <= rd_i;
              wb_data_o    <= ex_data_i;
            end else if (is_mem) begin
              data_req_o   <= 1'b1;
              data_addr_o  <= {ex_data_i[WORD_WIDTH-1:2], 2'b00};
              data_we_o    <= mem_write_i;
              data_be_o    <= be;
              data_wdata_o <= mem_write_i ? wdata : '0;
              is_store_q   <= mem_write_i;
              reg_write_q  <= reg_write_i;
              funct3_q     <= funct3_i;
              off_q        <= off;
              rd_q         <= rd_i;
              state        <= REQ;
            end else begin
              wb_valid_o <= 1'b1;
              wb_we_o    <= reg_write_i;
              wb_rd_o    <= rd_i;
              wb_data_o  <= ex_data_i;
            end
          end
        end
        REQ: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (data_rvalid_i) begin
            wb_valid_o <= 1'b1;
            wb_we_o    <= ~is_store_q & reg_write_q;
            wb_rd_o    <= rd_q;
            wb_data_o  <= is_store_q ? '0 : load_data;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage; the reference model derives lanes and load results
// arithmetically from address, size and sign. Honours LSU_MISALIGN_TRAP_EN like the design.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] ex_data_i = '0;
  logic [31:0] rdata2_store_i = '0;
  logic [2:0]  funct3_i = '0;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic        reg_write_i = 1'b0;
  logic [4:0]  rd_i = '0;
  logic        wb_valid_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misaligned_o;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i = '0;

  int checks = 0;
  int errors = 0;

  lsu_stage #(.WORD_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .ex_data_i(ex_data_i), .rdata2_store_i(rdata2_store_i), .funct3_i(funct3_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .reg_write_i(reg_write_i),
    .rd_i(rd_i), .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .misaligned_o(misaligned_o), .data_req_o(data_req_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rdata_i(data_rdata_i)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int unsigned m_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int unsigned m_off(input logic [31:0] a, input logic [2:0] f3);
    int unsigned sz = m_size(f3);
    return (a % 4) - ((a % 4) % sz);
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f3);
    int unsigned m = (1 << m_size(f3)) - 1;
    return 4'(m << m_off(a, f3));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] v, input logic [2:0] f3);
    int unsigned sz = m_size(f3);
    if (sz == 1) return (v & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (v & 32'hFFFF) * 32'h0001_0001;
    return v;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] a,
                                         input logic [2:0] f3);
    int unsigned sz = m_size(f3);
    logic [31:0] v = rdata >> (8 * m_off(a, f3));
    if (sz < 4) begin
      v = v & ((32'd1 << (8 * sz)) - 1);
      if ((f3 == 3'd0 || f3 == 3'd1) && v >= (32'd1 << (8 * sz - 1)))
        v = v | (32'hFFFF_FFFF << (8 * sz));
    end
    return v;
  endfunction

  function automatic bit m_misaligned(input logic [31:0] a, input logic [2:0] f3);
`ifdef LSU_MISALIGN_TRAP_EN
    return (a % m_size(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- transaction drivers ----------------
  // Called at #1 after a rising edge with the DUT in IDLE; ends one cycle after writeback.
  task automatic do_mem(input logic [31:0] addr, input logic [31:0] rs2, input logic [2:0] f3,
                        input bit st, input bit both, input bit rw, input logic [4:0] rd,
                        input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                        input bit stray);
    logic [31:0] exp_addr = addr & 32'hFFFF_FFFC;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mem_ready_idle got %b exp 1", ready_o); end
    valid_i = 1'b1; ex_data_i = addr; rdata2_store_i = rs2; funct3_i = f3;
    mem_write_i = st; mem_read_i = !st || both; reg_write_i = rw; rd_i = rd;
    @(posedge clk); #1;
    valid_i = 1'b0; mem_write_i = 1'b0; mem_read_i = 1'b0;
    ex_data_i = $urandom; rdata2_store_i = $urandom;
    if (m_misaligned(addr, f3)) begin
      checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL mis_wb_valid got %b exp 1", wb_valid_o); end
      checks++; if (misaligned_o !== 1'b1) begin errors++; $display("FAIL mis_flag got %b exp 1", misaligned_o); end
      checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL mis_we got %b exp 0", wb_we_o); end
      checks++; if (wb_data_o !== addr) begin errors++; $display("FAIL mis_data got %h exp %h", wb_data_o, addr); end
      checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL mis_req got %b exp 0", data_req_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mis_ready got %b exp 1", ready_o); end
      @(posedge clk); #1;
      checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL mis_pulse got %b exp 0", wb_valid_o); end
      return;
    end
    for (int i = 0; i < gnt_dly; i++) begin
      checks++; if (data_req_o !== 1'b1) begin errors++; $display("FAIL req_held got %b exp 1", data_req_o); end
      checks++; if (data_addr_o !== exp_addr) begin errors++; $display("FAIL addr_held got %h exp %h", data_addr_o, exp_addr); end
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL ready_req got %b exp 0", ready_o); end
      if (stray && i == 0) begin data_rvalid_i = 1'b1; data_rdata_i = $urandom; end
      @(posedge clk); #1;
      data_rvalid_i = 1'b0;
      checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL wb_in_req got %b exp 0", wb_valid_o); end
    end
    data_gnt_i = 1'b1;
    checks++; if (data_req_o !== 1'b1) begin errors++; $display("FAIL req got %b exp 1", data_req_o); end
    checks++; if (data_addr_o !== exp_addr) begin errors++; $display("FAIL addr got %h exp %h", data_addr_o, exp_addr); end
    checks++; if (data_be_o !== m_be(addr, f3)) begin errors++; $display("FAIL be got %b exp %b", data_be_o, m_be(addr, f3)); end
    checks++; if (data_we_o !== st) begin errors++; $display("FAIL we got %b exp %b", data_we_o, st); end
    if (st) begin
      checks++; if (data_wdata_o !== m_wdata(rs2, f3)) begin errors++; $display("FAIL wdata got %h exp %h", data_wdata_o, m_wdata(rs2, f3)); end
    end
    @(posedge clk); #1;
    data_gnt_i = 1'b0;
    checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL req_resp got %b exp 0", data_req_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL ready_resp got %b exp 0", ready_o); end
    for (int i = 1; i < rv_dly; i++) begin
      @(posedge clk); #1;
      checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL wb_in_resp got %b exp 0", wb_valid_o); end
    end
    data_rvalid_i = 1'b1; data_rdata_i = rdata;
    @(posedge clk); #1;
    data_rvalid_i = 1'b0; data_rdata_i = $urandom;
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL wb_valid got %b exp 1", wb_valid_o); end
    checks++; if (wb_we_o !== (!st && rw)) begin errors++; $display("FAIL wb_we got %b exp %b", wb_we_o, !st && rw); end
    checks++; if (wb_rd_o !== rd) begin errors++; $display("FAIL wb_rd got %0d exp %0d", wb_rd_o, rd); end
    checks++; if (wb_data_o !== (st ? 32'd0 : m_load(rdata, addr, f3))) begin errors++; $display("FAIL wb_data got %h exp %h", wb_data_o, st ? 32'd0 : m_load(rdata, addr, f3)); end
    checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL wb_mis got %b exp 0", misaligned_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL ready_wb got %b exp 1", ready_o); end
    @(posedge clk); #1;
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL wb_pulse got %b exp 0", wb_valid_o); end
  endtask

  task automatic do_alu(input logic [31:0] d, input logic [4:0] rd, input bit rw);
    valid_i = 1'b1; ex_data_i = d; rd_i = rd; reg_write_i = rw;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL alu_valid got %b exp 1", wb_valid_o); end
    checks++; if (wb_we_o !== rw) begin errors++; $display("FAIL alu_we got %b exp %b", wb_we_o, rw); end
    checks++; if (wb_rd_o !== rd) begin errors++; $display("FAIL alu_rd got %0d exp %0d", wb_rd_o, rd); end
    checks++; if (wb_data_o !== d) begin errors++; $display("FAIL alu_data got %h exp %h", wb_data_o, d); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL alu_ready got %b exp 1", ready_o); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", ready_o); end
    checks++; if ({wb_valid_o, wb_we_o, misaligned_o, data_req_o, data_we_o} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b exp 00000", {wb_valid_o, wb_we_o, misaligned_o, data_req_o, data_we_o}); end
    checks++; if ({wb_rd_o, data_be_o} !== 9'b0) begin errors++; $display("FAIL rst_rd_be got %h exp 0", {wb_rd_o, data_be_o}); end
    checks++; if ({wb_data_o, data_addr_o, data_wdata_o} !== 96'b0) begin errors++; $display("FAIL rst_data got %h exp 0", {wb_data_o, data_addr_o, data_wdata_o}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3] = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; ex_data_i = d[i]; rd_i = 5'(i + 1); reg_write_i = 1'b1;
      mem_read_i = 1'b0; mem_write_i = 1'b0;
      @(posedge clk); #1;
      checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d got %b exp 1", i, wb_valid_o); end
      checks++; if (wb_rd_o !== 5'(i + 1)) begin errors++; $display("FAIL b2b_rd%0d got %0d exp %0d", i, wb_rd_o, i + 1); end
      checks++; if (wb_data_o !== d[i]) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", i, wb_data_o, d[i]); end
    end
    valid_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", wb_valid_o); end
  endtask

  task automatic test_store_byte();
    do_mem(32'h1003, 32'hAABBCCDD, 3'b000, 1'b1, 1'b0, 1'b1, 5'd7, 0, 1, 32'h0, 1'b0);
    do_mem(32'h1002, 32'hAABBCCDD, 3'b001, 1'b1, 1'b1, 1'b0, 5'd8, 1, 2, 32'h0, 1'b0);
  endtask

  task automatic test_loads();
    do_mem(32'h2002, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd4, 0, 1, 32'h0080_0000, 1'b0);
    do_mem(32'h2002, 32'h0, 3'b100, 1'b0, 1'b0, 1'b1, 5'd5, 0, 1, 32'h0080_0000, 1'b0);
    do_mem(32'h2002, 32'h0, 3'b101, 1'b0, 1'b0, 1'b1, 5'd6, 0, 1, 32'h8001_0000, 1'b0);
    do_mem(32'h2002, 32'h0, 3'b001, 1'b0, 1'b0, 1'b1, 5'd9, 0, 1, 32'h8001_0000, 1'b0);
  endtask

  task automatic test_stall_lw();
    do_mem(32'h4000, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1, 5'd10, 4, 3, 32'hDEAD_BEEF, 1'b1);
  endtask

  task automatic test_reset_in_flight();
    valid_i = 1'b1; ex_data_i = 32'h5000; funct3_i = 3'b010; mem_read_i = 1'b1; rd_i = 5'd11; reg_write_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; mem_read_i = 1'b0;
    rst_n = 1'b0; #1;
    checks++; if (data_req_o !== 1'b0) begin errors++; $display("FAIL rstreq_req got %b exp 0", data_req_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rstreq_ready got %b exp 1", ready_o); end
    @(posedge clk); #1 rst_n = 1'b1;
    valid_i = 1'b1; mem_read_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; mem_read_i = 1'b0; data_gnt_i = 1'b1;
    @(posedge clk); #1;
    data_gnt_i = 1'b0;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rstresp_pre got %b exp 0", ready_o); end
    rst_n = 1'b0; #1;
    checks++; if ({data_req_o, wb_valid_o} !== 2'b00) begin errors++; $display("FAIL rstresp_drop got %b exp 00", {data_req_o, wb_valid_o}); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rstresp_ready got %b exp 1", ready_o); end
    @(posedge clk); #1 rst_n = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
    @(posedge clk); #1;
    data_rvalid_i = 1'b0;
    repeat (2) begin
      checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL rstresp_late got %b exp 0", wb_valid_o); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_misalign();
    do_mem(32'h3002, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1, 5'd12, 0, 1, 32'hCAFE_F00D, 1'b0);
    do_mem(32'h3001, 32'hBEEF, 3'b001, 1'b1, 1'b0, 1'b0, 5'd13, 0, 1, 32'h0, 1'b0);
    do_mem(32'h3003, 32'h0, 3'b101, 1'b0, 1'b0, 1'b1, 5'd14, 0, 1, 32'hF00D_CAFE, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] codes [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_alu($urandom, 5'($urandom), 1'($urandom));
        @(posedge clk); #1;
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL rnd_alu_pulse got %b exp 0", wb_valid_o); end
      end else begin
        do_mem($urandom, $urandom, codes[$urandom_range(0, 7)], 1'($urandom), 1'($urandom),
               1'($urandom), 5'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
               $urandom, 1'($urandom));
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_store_byte();
    test_loads();
    test_stall_lw();
    test_reset_in_flight();
    test_misalign();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
